apb2axi_rd_cpl_collector: RTL and testbench
===========================================

# apb2axi_rd_cpl_collector

Read-completion collector between the AXI R channel and the directory's completion port. It accepts R beats for up to 2^TAG_W outstanding tags (RID == directory tag) and forwards each beat's data to the read-data buffer with a per-tag beat index. It keeps a per-tag beat count and merged response, and on RLAST pushes one completion entry into a small FIFO that drains to the directory via cq_dir_cpl_vld/rdy.

## Interface
- TAG_W, 4: tag width; the tracking table has 2^TAG_W entries.
- DATA_W, 64: RDATA width.
- NB_W, 9: beat-count width, with a maximum count of 2^NB_W-1.
- CPL_DEPTH, 4: completion FIFO depth, a power of 2 that is at least 2.

Ports:
- pclk  in  1  clock; the block is single-clock.
- preset  in  1  asynchronous, active-high reset.
- rvalid  in  1  AXI R valid.
- rready  out  1  AXI R ready.
- rid  in  TAG_W  AXI RID, used as the tag.
- rdata  in  DATA_W  AXI RDATA.
- rresp  in  2  AXI RRESP.
- rlast  in  1  AXI RLAST.
- data_wr_vld  out  1  beat write strobe to the read-data buffer; the buffer always accepts.
- data_wr_tag  out  TAG_W  tag of the beat.
- data_wr_idx  out  NB_W  beat index within the burst, starting at 0.
- data_wr_data  out  DATA_W  beat data.
- cq_dir_cpl_vld  out  1  completion valid to the directory.
- cq_dir_cpl_entry  out  completion_entry_t  completion entry with fields {tag, resp[1:0], num_beats[NB_W-1:0], error}.
- cq_dir_cpl_rdy  in  1  directory accepts the completion.

## Operation
- R handshake: hs = rvalid && rready.
- rready = !preset && (fifo_count < CPL_DEPTH).
  - rready is registered-count based only; it has no combinational path from cq_dir_cpl_rdy.
  - rready also gates non-last beats, which keeps the logic simple.
- Per-tag table, indexed by rid:
  - cnt[NB_W], reset 0.
  - wresp[2], reset OKAY (0).
  - ovf[1], reset 0.
- On hs:
  - data_wr_vld=1, data_wr_tag=rid, data_wr_idx=cnt[rid], data_wr_data=rdata. These are combinational, in the same cycle as hs.
  - Merged response m = max(wresp[rid], rresp), using numeric max: DECERR(3) > SLVERR(2) > EXOKAY(1) > OKAY(0).
  - If rlast=0: wresp[rid] <= m. If cnt[rid] == 2^NB_W-1, set ovf[rid] <= 1 and hold cnt (saturate). Otherwise cnt[rid] <= cnt[rid]+1.
  - If rlast=1: push {tag=rid, resp=m, num_beats=sat(cnt[rid]+1), error=m[1] | ovf[rid] | (cnt[rid]+1 overflowed)} into the FIFO. In the same edge, clear cnt[rid], wresp[rid] and ovf[rid] to their reset values.
- Beats of different tags may interleave freely; each tag's state is independent.
- FIFO:
  - Circular buffer of CPL_DEPTH entries with wr_ptr, rd_ptr and a count of width clog2(CPL_DEPTH)+1.
  - Pointers wrap modulo CPL_DEPTH.
  - cq_dir_cpl_vld = (count != 0). cq_dir_cpl_entry = mem[rd_ptr], or all-zero when the FIFO is empty.
  - Pop on cq_dir_cpl_vld && cq_dir_cpl_rdy.
  - Push and pop in the same cycle leaves count unchanged. This is legal at any count, including CPL_DEPTH-1; push while full cannot occur because rready=0.
- Completions leave in RLAST order, including across tags.
- The block never stalls on the data path except through FIFO fullness.

## Timing
- Reset (asynchronous, preset=1):
  - All table entries, pointers and count are cleared.
  - cq_dir_cpl_vld=0, cq_dir_cpl_entry=0, data_wr_vld=0, rready=0.
- First cycle after release: rready=1.
- Beat-to-buffer latency is 0 cycles: data_wr_* is valid in the hs cycle.
- RLAST-to-completion latency: cq_dir_cpl_vld rises on the pclk edge following the RLAST hs, provided the FIFO was empty.
- Full: after the push that brings count to CPL_DEPTH, rready=0 from the next cycle. rready returns to 1 on the cycle after the first pop.
- Reset asserted mid-burst:
  - The partial burst state is discarded and queued completions are lost.
  - Outputs go to reset values immediately (asynchronously).
- cq_dir_cpl_entry is held stable while cq_dir_cpl_vld=1 and cq_dir_cpl_rdy=0.

## Test plan
- Single burst: tag 3, 4 beats, all OKAY, cq_dir_cpl_rdy=1.
  - data_wr_idx must be 0, 1, 2, 3.
  - One cycle after RLAST: one completion {tag=3, resp=0, num_beats=4, error=0}.
- Response merge: tag 5, 3 beats with rresp 0, 2, 1.
  - Completion must be {tag=5, resp=2, num_beats=3, error=1}.
  - A following 1-beat OKAY burst on tag 5 must give resp=0, error=0 (state was cleared).
- Interleave: beats alternate between tag 1 (2 beats) and tag 2 (3 beats).
  - Per-tag indices must be independent.
  - Completions must be {1, beats=2} then {2, beats=3}, in RLAST order.
- Backpressure: cq_dir_cpl_rdy=0, issue 5 single-beat bursts with tags 0..4.
  - rready must drop after the 4th push, with count=4.
  - Raising rdy must drain tags 0, 1, 2, 3. rready=1 must return on the cycle after the first pop, and tag 4 then completes.
  - Also cover simultaneous push and pop at count=3: count must stay 3.
- Reset mid-burst: tag 7 has 2 of 4 beats accepted, then preset is pulsed.
  - All outputs must be 0 while preset=1, with no completion for tag 7.
  - A new 1-beat burst on tag 7 must report num_beats=1.
- Overflow: 512 beats on tag 0 with NB_W=9. num_beats must saturate at 511 and error must be 1.

Source files
------------

// File: rtl/apb2axi_rd_cpl_collector.sv
// AXI R-channel completion collector: per-tag beat counting and response merging,
// with an in-order completion FIFO that drains to the directory.

package apb2axi_rd_cpl_pkg;
   localparam int CPL_TAG_W = 4;
   localparam int CPL_NB_W  = 9;

   typedef struct packed {
      logic [CPL_TAG_W-1:0] tag;
      logic [1:0]           resp;
      logic [CPL_NB_W-1:0]  num_beats;
      logic                 error;
   } completion_entry_t;
endpackage

module apb2axi_rd_cpl_collector
   import apb2axi_rd_cpl_pkg::*;
#(
   parameter int TAG_W     = CPL_TAG_W,
   parameter int DATA_W    = 64,
   parameter int NB_W      = CPL_NB_W,
   parameter int CPL_DEPTH = 4
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              rvalid,
   output logic              rready,
   input  logic [TAG_W-1:0]  rid,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   output logic              data_wr_vld,
   output logic [TAG_W-1:0]  data_wr_tag,
   output logic [NB_W-1:0]   data_wr_idx,
   output logic [DATA_W-1:0] data_wr_data,
   output logic              cq_dir_cpl_vld,
   output completion_entry_t cq_dir_cpl_entry,
   input  logic              cq_dir_cpl_rdy
);

   localparam int NTAG = 1 << TAG_W;
   localparam int PW   = $clog2(CPL_DEPTH);
   localparam int CW   = PW + 1;
   localparam logic [NB_W-1:0] CNT_MAX = '1;
   localparam logic [CW-1:0]   DEPTH_C = CW'(CPL_DEPTH);

   logic [NTAG-1:0][NB_W-1:0] w_cnt_arr;
   logic [NTAG-1:0][1:0]      w_wresp_arr;
   logic [NTAG-1:0]           w_ovf_arr;

   logic                      w_hs;
   logic [NB_W-1:0]           w_cnt_cur;
   logic [1:0]                w_wresp_cur;
   logic                      w_ovf_cur;
   logic [1:0]                w_merge;
   logic                      w_cnt_sat;
   logic                      w_push;
   logic                      w_pop;
   completion_entry_t         w_push_entry;

   completion_entry_t         r_mem [CPL_DEPTH];
   logic [PW-1:0]             r_wr_ptr;
   logic [PW-1:0]             r_rd_ptr;
   logic [CW-1:0]             r_count;

   // Ready depends only on the registered FIFO count, never on cq_dir_cpl_rdy.
   assign rready = !preset && (r_count < DEPTH_C);
   assign w_hs   = rvalid && rready;

   assign w_cnt_cur   = w_cnt_arr[rid];
   assign w_wresp_cur = w_wresp_arr[rid];
   assign w_ovf_cur   = w_ovf_arr[rid];
   assign w_merge     = (rresp > w_wresp_cur) ? rresp : w_wresp_cur;
   assign w_cnt_sat   = (w_cnt_cur == CNT_MAX);

   assign data_wr_vld  = w_hs;
   assign data_wr_tag  = w_hs ? rid       : '0;
   assign data_wr_idx  = w_hs ? w_cnt_cur : '0;
   assign data_wr_data = w_hs ? rdata     : '0;

   generate
      for (genvar gi = 0; gi < NTAG; gi++) begin : g_tag
         logic [NB_W-1:0] r_cnt;
         logic [1:0]      r_wresp;
         logic            r_ovf;
         logic            w_sel;

         assign w_sel          = w_hs && (rid == TAG_W'(gi));
         assign w_cnt_arr[gi]   = r_cnt;
         assign w_wresp_arr[gi] = r_wresp;
         assign w_ovf_arr[gi]   = r_ovf;

         always_ff @(posedge pclk or posedge preset) begin
            if (preset) begin
               r_cnt   <= '0;
               r_wresp <= 2'b00;
               r_ovf   <= 1'b0;
            end else if (w_sel) begin
               if (rlast) begin
                  r_cnt   <= '0;
                  r_wresp <= 2'b00;
                  r_ovf   <= 1'b0;
               end else begin
                  r_wresp <= w_merge;
                  if (w_cnt_sat)
                     r_ovf <= 1'b1;
                  else
                     r_cnt <= w_cnt_cur + 1'b1;
               end
            end
         end
      end
   endgenerate

   // A last beat arriving at a saturated count overflows the beat total as well.
   always_comb begin
      w_push_entry           = '0;
      w_push_entry.tag       = rid;
      w_push_entry.resp      = w_merge;
      w_push_entry.num_beats = w_cnt_sat ? CNT_MAX : (w_cnt_cur + 1'b1);
      w_push_entry.error     = w_merge[1] | w_ovf_cur | w_cnt_sat;
   end

   assign w_push = w_hs && rlast;
   assign w_pop  = cq_dir_cpl_vld && cq_dir_cpl_rdy;

   always_ff @(posedge pclk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= w_push_entry;
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign cq_dir_cpl_vld   = (r_count != '0);
   assign cq_dir_cpl_entry = cq_dir_cpl_vld ? r_mem[r_rd_ptr] : '0;

endmodule

// File: tb/tb_apb2axi_rd_cpl_collector.sv
// Directed bench for apb2axi_rd_cpl_collector: beat indexing, response merge,
// interleave, FIFO backpressure, mid-burst reset and beat-count saturation.

module tb_apb2axi_rd_cpl_collector;
   import apb2axi_rd_cpl_pkg::*;

   localparam int TAG_W  = 4;
   localparam int DATA_W = 64;
   localparam int NB_W   = 9;
   localparam int DEPTH  = 4;

   logic              pclk = 1'b0;
   logic              preset;
   logic              rvalid;
   logic              rready;
   logic [TAG_W-1:0]  rid;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic              data_wr_vld;
   logic [TAG_W-1:0]  data_wr_tag;
   logic [NB_W-1:0]   data_wr_idx;
   logic [DATA_W-1:0] data_wr_data;
   logic              cq_dir_cpl_vld;
   completion_entry_t cq_dir_cpl_entry;
   logic              cq_dir_cpl_rdy;

   int n_checks = 0;
   int n_fail   = 0;

   apb2axi_rd_cpl_collector #(
      .TAG_W(TAG_W), .DATA_W(DATA_W), .NB_W(NB_W), .CPL_DEPTH(DEPTH)
   ) dut (
      .pclk(pclk), .preset(preset),
      .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata),
      .rresp(rresp), .rlast(rlast),
      .data_wr_vld(data_wr_vld), .data_wr_tag(data_wr_tag),
      .data_wr_idx(data_wr_idx), .data_wr_data(data_wr_data),
      .cq_dir_cpl_vld(cq_dir_cpl_vld), .cq_dir_cpl_entry(cq_dir_cpl_entry),
      .cq_dir_cpl_rdy(cq_dir_cpl_rdy)
   );

   always #5 pclk = ~pclk;

   // Called at posedge+1; drives one beat, checks the 0-latency buffer write, returns at next posedge+1.
   task automatic beat(input int tag, input logic [63:0] data, input logic [1:0] resp,
                       input bit last, input int exp_idx);
      logic [TAG_W-1:0] t;
      logic [NB_W-1:0]  ei;
      t  = tag[TAG_W-1:0];
      ei = exp_idx[NB_W-1:0];
      rvalid = 1'b1; rid = t; rdata = data; rresp = resp; rlast = last;
      #3;
      n_checks++;
      if (rready !== 1'b1 || data_wr_vld !== 1'b1) begin
         n_fail++;
         $display("FAIL beat_hs tag=%0d idx=%0d: rready=%b data_wr_vld=%b, required 1 and 1",
                  tag, exp_idx, rready, data_wr_vld);
      end
      n_checks++;
      if (data_wr_tag !== t || data_wr_idx !== ei || data_wr_data !== data) begin
         n_fail++;
         $display("FAIL beat_data: got tag=%0d idx=%0d data=%h, required tag=%0d idx=%0d data=%h",
                  data_wr_tag, data_wr_idx, data_wr_data, t, ei, data);
      end
      @(posedge pclk); #1;
      rvalid = 1'b0; rlast = 1'b0;
   endtask

   // Called at posedge+1; accepts one completion and compares it.
   task automatic pop_check(input int tag, input int resp, input int nb, input bit err);
      completion_entry_t exp;
      exp.tag       = tag[TAG_W-1:0];
      exp.resp      = resp[1:0];
      exp.num_beats = nb[NB_W-1:0];
      exp.error     = err;
      cq_dir_cpl_rdy = 1'b1;
      #3;
      n_checks++;
      if (cq_dir_cpl_vld !== 1'b1 || cq_dir_cpl_entry !== exp) begin
         n_fail++;
         $display("FAIL cpl: got vld=%b tag=%0d resp=%0d beats=%0d err=%b, required vld=1 tag=%0d resp=%0d beats=%0d err=%b",
                  cq_dir_cpl_vld, cq_dir_cpl_entry.tag, cq_dir_cpl_entry.resp,
                  cq_dir_cpl_entry.num_beats, cq_dir_cpl_entry.error,
                  exp.tag, exp.resp, exp.num_beats, exp.error);
      end
      $display("completion tag=%0d resp=%0d beats=%0d err=%b", cq_dir_cpl_entry.tag,
               cq_dir_cpl_entry.resp, cq_dir_cpl_entry.num_beats, cq_dir_cpl_entry.error);
      @(posedge pclk); #1;
      cq_dir_cpl_rdy = 1'b0;
   endtask

   task automatic test_reset();
      preset = 1'b1;
      repeat (3) @(posedge pclk);
      #1;
      n_checks++;
      if (rready !== 1'b0 || data_wr_vld !== 1'b0 || cq_dir_cpl_vld !== 1'b0 || cq_dir_cpl_entry !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: rready=%b data_wr_vld=%b cpl_vld=%b entry=%h, required all 0",
                  rready, data_wr_vld, cq_dir_cpl_vld, cq_dir_cpl_entry);
      end
      preset = 1'b0;
      #3;
      n_checks++;
      if (rready !== 1'b1 || cq_dir_cpl_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: rready=%b cpl_vld=%b, required 1 and 0", rready, cq_dir_cpl_vld);
      end
      @(posedge pclk); #1;
   endtask

   task automatic test_single_burst();
      n_checks++;
      if (cq_dir_cpl_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL single_idle: cpl_vld=%b, required 0", cq_dir_cpl_vld);
      end
      for (int i = 0; i < 4; i++)
         beat(3, 64'hA000 + 64'(i), 2'b00, i == 3, i);
      pop_check(3, 0, 4, 1'b0);
      #3;
      n_checks++;
      if (cq_dir_cpl_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL single_drained: cpl_vld=%b, required 0", cq_dir_cpl_vld);
      end
      @(posedge pclk); #1;
   endtask

   task automatic test_resp_merge();
      beat(5, 64'hB0, 2'b00, 1'b0, 0);
      beat(5, 64'hB1, 2'b10, 1'b0, 1);
      beat(5, 64'hB2, 2'b01, 1'b1, 2);
      pop_check(5, 2, 3, 1'b1);
      beat(5, 64'hB3, 2'b00, 1'b1, 0);
      pop_check(5, 0, 1, 1'b0);
   endtask

   task automatic test_interleave();
      beat(1, 64'hC10, 2'b00, 1'b0, 0);
      beat(2, 64'hC20, 2'b00, 1'b0, 0);
      beat(1, 64'hC11, 2'b00, 1'b1, 1);
      beat(2, 64'hC21, 2'b00, 1'b0, 1);
      beat(2, 64'hC22, 2'b00, 1'b1, 2);
      pop_check(1, 0, 2, 1'b0);
      pop_check(2, 0, 3, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int t = 0; t < 4; t++)
         beat(t, 64'hD00 + 64'(t), 2'b00, 1'b1, 0);
      // FIFO now holds 4 entries; tag 4 must stall.
      rvalid = 1'b1; rid = 4'd4; rdata = 64'hD04; rresp = 2'b00; rlast = 1'b1;
      #3;
      n_checks++;
      if (rready !== 1'b0 || data_wr_vld !== 1'b0 || cq_dir_cpl_entry.tag !== 4'd0) begin
         n_fail++;
         $display("FAIL full_stall: rready=%b data_wr_vld=%b head_tag=%0d, required 0 0 0",
                  rready, data_wr_vld, cq_dir_cpl_entry.tag);
      end
      @(posedge pclk); #1;
      cq_dir_cpl_rdy = 1'b1;
      #3;
      n_checks++;
      if (rready !== 1'b0 || cq_dir_cpl_vld !== 1'b1 || cq_dir_cpl_entry.tag !== 4'd0) begin
         n_fail++;
         $display("FAIL full_hold: rready=%b cpl_vld=%b head_tag=%0d, required 0 1 0",
                  rready, cq_dir_cpl_vld, cq_dir_cpl_entry.tag);
      end
      $display("completion tag=%0d (drain)", cq_dir_cpl_entry.tag);
      @(posedge pclk); #1;
      // Count is 3: tag 4 pushes while tag 1 pops.
      #3;
      n_checks++;
      if (rready !== 1'b1 || data_wr_vld !== 1'b1 || data_wr_tag !== 4'd4 || data_wr_idx !== 9'd0) begin
         n_fail++;
         $display("FAIL ready_return: rready=%b data_wr_vld=%b tag=%0d idx=%0d, required 1 1 4 0",
                  rready, data_wr_vld, data_wr_tag, data_wr_idx);
      end
      n_checks++;
      if (cq_dir_cpl_entry.tag !== 4'd1) begin
         n_fail++;
         $display("FAIL drain_order1: head_tag=%0d, required 1", cq_dir_cpl_entry.tag);
      end
      $display("completion tag=%0d (drain with push)", cq_dir_cpl_entry.tag);
      @(posedge pclk); #1;
      rvalid = 1'b0; rlast = 1'b0; cq_dir_cpl_rdy = 1'b0;
      #3;
      n_checks++;
      if (rready !== 1'b1 || cq_dir_cpl_entry.tag !== 4'd2) begin
         n_fail++;
         $display("FAIL push_pop_count: rready=%b head_tag=%0d, required 1 2", rready, cq_dir_cpl_entry.tag);
      end
      @(posedge pclk); #1;
      beat(6, 64'hD06, 2'b00, 1'b1, 0);
      #3;
      n_checks++;
      if (rready !== 1'b0) begin
         n_fail++;
         $display("FAIL refull: rready=%b, required 0 (count must have stayed 3)", rready);
      end
      @(posedge pclk); #1;
      pop_check(2, 0, 1, 1'b0);
      pop_check(3, 0, 1, 1'b0);
      pop_check(4, 0, 1, 1'b0);
      pop_check(6, 0, 1, 1'b0);
      #3;
      n_checks++;
      if (cq_dir_cpl_vld !== 1'b0 || cq_dir_cpl_entry !== '0 || rready !== 1'b1) begin
         n_fail++;
         $display("FAIL empty_after_drain: cpl_vld=%b entry=%h rready=%b, required 0 0 1",
                  cq_dir_cpl_vld, cq_dir_cpl_entry, rready);
      end
      @(posedge pclk); #1;
   endtask

   task automatic test_reset_mid_burst();
      beat(9, 64'hE09, 2'b00, 1'b1, 0);
      beat(7, 64'hE70, 2'b00, 1'b0, 0);
      beat(7, 64'hE71, 2'b00, 1'b0, 1);
      rvalid = 1'b1; rid = 4'd7; rdata = 64'hE72; rresp = 2'b00; rlast = 1'b0;
      preset = 1'b1;
      #1;
      n_checks++;
      if (rready !== 1'b0 || data_wr_vld !== 1'b0 || data_wr_tag !== '0 || data_wr_idx !== '0 ||
          data_wr_data !== '0 || cq_dir_cpl_vld !== 1'b0 || cq_dir_cpl_entry !== '0) begin
         n_fail++;
         $display("FAIL async_reset: rready=%b wr_vld=%b tag=%0d idx=%0d data=%h cpl_vld=%b entry=%h, required all 0",
                  rready, data_wr_vld, data_wr_tag, data_wr_idx, data_wr_data, cq_dir_cpl_vld, cq_dir_cpl_entry);
      end
      @(posedge pclk); #1;
      n_checks++;
      if (rready !== 1'b0 || data_wr_vld !== 1'b0 || cq_dir_cpl_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_held: rready=%b wr_vld=%b cpl_vld=%b, required 0 0 0",
                  rready, data_wr_vld, cq_dir_cpl_vld);
      end
      preset = 1'b0; rvalid = 1'b0;
      #3;
      n_checks++;
      if (rready !== 1'b1 || cq_dir_cpl_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flush: rready=%b cpl_vld=%b, required 1 0", rready, cq_dir_cpl_vld);
      end
      @(posedge pclk); #1;
      beat(7, 64'hE7F, 2'b00, 1'b1, 0);
      pop_check(7, 0, 1, 1'b0);
      #3;
      n_checks++;
      if (cq_dir_cpl_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_no_stale: cpl_vld=%b, required 0", cq_dir_cpl_vld);
      end
      @(posedge pclk); #1;
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 512; i++)
         beat(0, 64'(i), 2'b00, i == 511, i);
      pop_check(0, 0, 511, 1'b1);
      beat(0, 64'hF00, 2'b00, 1'b1, 0);
      pop_check(0, 0, 1, 1'b0);
   endtask

   initial begin
      preset = 1'b1; rvalid = 1'b0; rid = '0; rdata = '0; rresp = 2'b00;
      rlast = 1'b0; cq_dir_cpl_rdy = 1'b0;
      test_reset();
      test_single_burst();
      test_resp_merge();
      test_interleave();
      test_back_to_back();
      test_reset_mid_burst();
      test_overflow();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
